// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive sampler.
// Holds the default counter widths, the prescale floor and reset value,
// the idle level of the serial line and the 3-input majority vote.
package uart_rx_pkg;

  localparam int DEF_PRESCALE_WIDTH = 5;
  localparam int DEF_BIT_CNT_WIDTH  = 4;

  // Smallest legal oversampling ratio; also the prescale register's reset value.
  localparam int MIN_PRESCALE = 8;
  localparam int PRESCALE_RST = MIN_PRESCALE;

  // A UART line idles high (mark).
  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both flops reset to the line's idle level, so a reset never looks like a
// start bit.  The module is compiled only when UART_RX_SYNC_EN is defined,
// because it is instantiated only in that build.
// Ports:
//   clk  - receiver clock
//   rst  - asynchronous active-high reset
//   d    - raw serial line
//   q    - line resynchronised to clk, two cycles late
`ifdef UART_RX_SYNC_EN
module uart_rx_sync2
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= IDLE_LEVEL;
      sync_p1 <= IDLE_LEVEL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule
`endif

// File: rtl/uart_rx_sampler.sv
// UART receiver front-end: oversampling edge counter, bit counter and a
// three-sample majority vote around mid-bit.  One decided bit is produced
// per bit period together with a one-cycle valid strobe.
//
// Build option: UART_RX_SYNC_EN.  When defined, RX_IN passes through a
// two-flop synchronizer (uart_rx_sync2) and every sample point sees the pin
// two cycles late; the counters are not affected.  When undefined, RX_IN is
// used directly and must already be synchronous to CLK.
//
// Ports:
//   CLK          - receiver clock at the oversampling rate
//   RST          - asynchronous active-high reset
//   RX_IN        - serial line, idles high
//   Cnt_En       - runs the edge and bit counters while high
//   Dat_Samp_En  - enables sampling and voting
//   Prescale     - oversampling ratio (even, 8 .. 2^PRESCALE_WIDTH-2)
//   Edge_Cnt     - position within the current bit, 0 .. P-1
//   Bit_Cnt      - bit index within the frame, saturating
//   Sampled_Bit  - majority-voted bit value
//   Samp_Valid   - one-cycle strobe, Sampled_Bit was updated on this edge
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
  parameter int BIT_CNT_WIDTH  = DEF_BIT_CNT_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      Cnt_En,
  input  logic                      Dat_Samp_En,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
  output logic [BIT_CNT_WIDTH-1:0]  Bit_Cnt,
  output logic                      Sampled_Bit,
  output logic                      Samp_Valid
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE   = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] P_RST = PRESCALE_WIDTH'(PRESCALE_RST);
  localparam logic [BIT_CNT_WIDTH-1:0]  B_MAX = '1;

  logic                      line;
  logic                      run;
  logic                      counting;
  logic                      wrap;
  logic [PRESCALE_WIDTH-1:0] p_reg;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] half_m1;
  logic [PRESCALE_WIDTH-1:0] half_p1;
  logic [PRESCALE_WIDTH-1:0] p_m1;
  logic                      s0;
  logic                      s1;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync2 u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (RX_IN),
    .q   (line)
  );
`else
  assign line = RX_IN;
`endif

  // run remembers that Cnt_En was already high on the previous edge, so the
  // first enabled edge parks Edge_Cnt at 0 and counting starts on the next.
  always_comb begin
    half     = p_reg >> 1;
    half_m1  = half - ONE;
    half_p1  = half + ONE;
    p_m1     = p_reg - ONE;
    counting = Cnt_En & run;
    wrap     = counting && (Edge_Cnt == p_m1);
  end

  // Stage: prescale register and counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run      <= 1'b0;
      p_reg    <= P_RST;
      Edge_Cnt <= '0;
      Bit_Cnt  <= '0;
    end else begin
      run <= Cnt_En;
      // The ratio is frozen for the whole frame so a mid-frame change of
      // Prescale cannot skew the bit timing.
      if (!Cnt_En) begin
        p_reg <= Prescale;
      end
      if (!counting) begin
        Edge_Cnt <= '0;
      end else if (wrap) begin
        Edge_Cnt <= '0;
      end else begin
        Edge_Cnt <= Edge_Cnt + ONE;
      end
      // Clearing on !Cnt_En takes priority over a coincident wrap.
      if (!Cnt_En) begin
        Bit_Cnt <= '0;
      end else if (wrap && (Bit_Cnt != B_MAX)) begin
        Bit_Cnt <= Bit_Cnt + 1'b1;
      end
    end
  end

  // Stage: mid-bit samples and majority vote
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0          <= IDLE_LEVEL;
      s1          <= IDLE_LEVEL;
      Sampled_Bit <= IDLE_LEVEL;
      Samp_Valid  <= 1'b0;
    end else begin
      Samp_Valid <= 1'b0;
      if (Dat_Samp_En) begin
        if (Edge_Cnt == half_m1) begin
          s0 <= line;
        end
        if (Edge_Cnt == half) begin
          s1 <= line;
        end
        // The third sample is the live line, so the decision is ready one
        // cycle after the last capture and stable while Edge_Cnt == H+2.
        if (Edge_Cnt == half_p1) begin
          Sampled_Bit <= majority3(s0, s1, line);
          Samp_Valid  <= 1'b1;
        end
      end
    end
  end

endmodule
